hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Stall/flush scheduler for the 5-stage pipeline. Compares D-stage operand
//  demand (Tuse) with E/M-stage result supply (Tnew) and sequences the
//  multi-cycle mult/div unit (MDU) with an internal busy counter.
//  Drives the PC and F/D register enables and the D/E register flush: while
//  stalled, PC and F/D hold and a bubble is inserted into E.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after a mult/multu issues in E (1..15)
//  DIV_CYCLES   10  busy cycles after a div/divu issues in E (1..15)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  D_rs         in   5   rs register number of the D instr
//  D_rt         in   5   rt register number of the D instr
//  D_tuse_rs    in   2   cycles until D instr needs rs (3 = not used)
//  D_tuse_rt    in   2   cycles until D instr needs rt (3 = not used)
//  D_md_use     in   1   D instr is mult/div/mfhi/mflo/mthi/mtlo
//  E_dst        in   5   dest register of the E instr (0 = none)
//  E_tnew       in   2   cycles until the E result is forwardable
//  M_dst        in   5   dest register of the M instr (0 = none)
//  M_tnew       in   2   cycles until the M result is forwardable
//  E_md_start   in   1   mult/div issuing in E this cycle
//  E_md_div     in   1   with E_md_start: 1 = div/divu, 0 = mult/multu
//  pc_en        out  1   PC update enable
//  fd_en        out  1   F/D register enable
//  de_flush     out  1   D/E register flush (bubble insert)
//  md_busy      out  1   MDU result pending
//  md_done      out  1   1-cycle pulse in the last busy cycle
//  stall_cnt    out  32  number of stalled cycles since reset, saturating
// BEHAVIOUR
//  - Reset (async, reset==0): cnt=0, stall_cnt=0 => md_busy=0, md_done=0,
//    stall=0 (given non-hazard inputs), pc_en=1, fd_en=1, de_flush=0.
//  - FSM on 4-bit cnt: IDLE (cnt==0), BUSY (cnt!=0).
//    IDLE: on edge with E_md_start: cnt <= E_md_div ? DIV_CYCLES : MULT_CYCLES.
//    BUSY: cnt <= cnt-1 each edge. If E_md_start arrives while BUSY
//    (illegal, stall prevents it), reload the counter; do not decrement.
//  - md_busy = (cnt!=0); md_done = (cnt==1); both combinational from cnt.
//  - stall_rs = (D_rs!=0) & ((D_rs==E_dst & E_tnew>D_tuse_rs) |
//               (D_rs==M_dst & M_tnew>D_tuse_rs)); stall_rt same with rt.
//    Unsigned 2-bit compares; register 0 never stalls.
//  - stall_md = D_md_use & (md_busy | E_md_start).
//  - stall = stall_rs | stall_rt | stall_md, combinational, same cycle.
//    pc_en = fd_en = ~stall; de_flush = stall. D/E enable is not driven here
//    (tie high); a flush wins over enable in the D/E register.
//  - stall_cnt += 1 on each edge where stall==1; holds at 32'hFFFFFFFF.
//  - Reset mid-BUSY aborts the MDU sequence immediately; no md_done pulse.
//  - Latency: stall reacts combinationally; MDU busy rises the cycle after
//    E_md_start and lasts exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
// TESTING
//  1 reset=0 with E_md_start=1 -> md_busy=0, pc_en=1, de_flush=0, stall_cnt=0.
//  2 D_rs=8,D_tuse_rs=0; E_dst=8,E_tnew=2 -> pc_en=0,fd_en=0,de_flush=1;
//    next cycle M_dst=8,M_tnew=1 -> still stalled; M_tnew=0 -> released.
//  3 D_rs=0,E_dst=0,E_tnew=2,D_tuse_rs=0 -> no stall; stall_cnt unchanged.
//  4 E_md_start=1,E_md_div=0 one cycle; D_md_use=1 -> stalled that cycle,
//    then md_busy=1 for 5 cycles, md_done in 5th, pc_en=1 in 6th.
//  5 div issue, reset pulled low at busy cycle 4 -> md_busy=0 immediately,
//    no md_done; after release D_md_use=1 -> no stall.
//  6 stall_cnt preset to 32'hFFFFFFFE by force, 3 stalled cycles
//    -> reads 32'hFFFFFFFF and holds.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard/stall controller: D-stage operand
// demand, E/M-stage result supply, MDU issue, and the resulting stall controls.
interface hazard_ctrl_if;
  logic [4:0]  D_rs;
  logic [4:0]  D_rt;
  logic [1:0]  D_tuse_rs;
  logic [1:0]  D_tuse_rt;
  logic        D_md_use;
  logic [4:0]  E_dst;
  logic [1:0]  E_tnew;
  logic [4:0]  M_dst;
  logic [1:0]  M_tnew;
  logic        E_md_start;
  logic        E_md_div;
  logic        pc_en;
  logic        fd_en;
  logic        de_flush;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cnt;

  // Pipeline side: supplies stage information, consumes stall controls.
  modport master (
    output D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md_use,
    output E_dst, E_tnew, M_dst, M_tnew, E_md_start, E_md_div,
    input  pc_en, fd_en, de_flush, md_busy, md_done, stall_cnt
  );

  // Controller side.
  modport slave (
    input  D_rs, D_rt, D_tuse_rs, D_tuse_rt, D_md_use,
    input  E_dst, E_tnew, M_dst, M_tnew, E_md_start, E_md_div,
    output pc_en, fd_en, de_flush, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline. Compares D-stage operand
// demand (Tuse) against E/M result availability (Tnew) and tracks the
// multi-cycle mult/div unit with a down-counter. While stalled, PC and F/D
// hold and a bubble goes into E; the D/E enable is tied high elsewhere.
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,   // asynchronous, active low
  hazard_ctrl_if.slave bus
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [0:0]  state;
  logic        stall_rs, stall_rt, stall_md, stall;

  // The FSM state is simply whether the MDU counter is still running.
  assign state = (cnt_q != 4'd0) ? ST_BUSY : ST_IDLE;

  assign bus.md_busy = (cnt_q != 4'd0);
  assign bus.md_done = (cnt_q == 4'd1);

  // Operand hazards: a producer whose result is not ready by the time the
  // consumer needs it forces a stall. Register 0 is hard-wired and never waits.
  assign stall_rs = (bus.D_rs != 5'd0) &&
                    (((bus.D_rs == bus.E_dst) && (bus.E_tnew > bus.D_tuse_rs)) ||
                     ((bus.D_rs == bus.M_dst) && (bus.M_tnew > bus.D_tuse_rs)));
  assign stall_rt = (bus.D_rt != 5'd0) &&
                    (((bus.D_rt == bus.E_dst) && (bus.E_tnew > bus.D_tuse_rt)) ||
                     ((bus.D_rt == bus.M_dst) && (bus.M_tnew > bus.D_tuse_rt)));

  // Any MDU access in D waits while an operation is in flight or just issuing.
  assign stall_md = bus.D_md_use && (bus.md_busy || bus.E_md_start);
  assign stall    = stall_rs || stall_rt || stall_md;

  assign bus.pc_en     = ~stall;
  assign bus.fd_en     = ~stall;
  assign bus.de_flush  = stall;
  assign bus.stall_cnt = stall_cnt_q;

  // Next-state for the MDU busy counter; a start while busy reloads it.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    cnt_d = cnt_q;
    case (state)
      ST_IDLE: begin
        if (bus.E_md_start) cnt_d = bus.E_md_div ? DIV_LOAD : MULT_LOAD;
      end
      ST_BUSY: begin
        if (bus.E_md_start) cnt_d = bus.E_md_div ? DIV_LOAD : MULT_LOAD;
        else                cnt_d = cnt_q - 4'd1;
      end
      default: cnt_d = 4'd0;
    endcase
  end

  // Next-state for the saturating stalled-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State registers; reset aborts any MDU sequence immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, away from the rising edge.
module tb_hazard_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] exp_cnt;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    hif.D_rs = 5'd0;  hif.D_rt = 5'd0;
    hif.D_tuse_rs = 2'd3; hif.D_tuse_rt = 2'd3;
    hif.D_md_use = 1'b0;
    hif.E_dst = 5'd0; hif.E_tnew = 2'd0;
    hif.M_dst = 5'd0; hif.M_tnew = 2'd0;
    hif.E_md_start = 1'b0; hif.E_md_div = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_stall(input string name, input logic exp_stall);
    checks++;
    if ({hif.pc_en, hif.fd_en, hif.de_flush} !== {~exp_stall, ~exp_stall, exp_stall}) begin
      failures++;
      $display("FAIL %s: pc_en/fd_en/de_flush=%b%b%b expected %b%b%b", name,
               hif.pc_en, hif.fd_en, hif.de_flush, ~exp_stall, ~exp_stall, exp_stall);
    end
  endtask

  task automatic chk_md(input string name, input logic exp_busy, input logic exp_done);
    checks++;
    if ({hif.md_busy, hif.md_done} !== {exp_busy, exp_done}) begin
      failures++;
      $display("FAIL %s: md_busy/md_done=%b%b expected %b%b", name,
               hif.md_busy, hif.md_done, exp_busy, exp_done);
    end
  endtask

  task automatic chk_cnt(input string name);
    checks++;
    if (hif.stall_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL %s: stall_cnt=%h expected %h", name, hif.stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    hif.E_md_start = 1'b1;
    hif.E_md_div = 1'b1;
    repeat (2) step();
    exp_cnt = 32'd0;
    chk_md("reset_md", 1'b0, 1'b0);
    chk_stall("reset_stall", 1'b0);
    chk_cnt("reset_cnt");
    hif.E_md_start = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk_md("after_reset_md", 1'b0, 1'b0);
  endtask

  task automatic test_raw_hazard();
    idle_inputs();
    hif.D_rs = 5'd8; hif.D_tuse_rs = 2'd0;
    hif.E_dst = 5'd8; hif.E_tnew = 2'd2;
    #1;
    chk_stall("rs_e_hazard", 1'b1);
    step(); exp_cnt += 1;
    chk_cnt("rs_e_cnt");
    hif.E_dst = 5'd0; hif.M_dst = 5'd8; hif.M_tnew = 2'd1;
    #1;
    chk_stall("rs_m_tnew1", 1'b1);
    step(); exp_cnt += 1;
    hif.M_tnew = 2'd0;
    #1;
    chk_stall("rs_m_tnew0", 1'b0);
    step();
    chk_cnt("rs_release_cnt");
    // rt path: equal Tnew/Tuse is forwardable, greater stalls
    idle_inputs();
    hif.D_rt = 5'd9; hif.D_tuse_rt = 2'd1;
    hif.M_dst = 5'd9; hif.M_tnew = 2'd1;
    #1;
    chk_stall("rt_equal", 1'b0);
    hif.M_tnew = 2'd2;
    #1;
    chk_stall("rt_greater", 1'b1);
    step(); exp_cnt += 1;
    hif.E_dst = 5'd9; hif.E_tnew = 2'd2; hif.M_dst = 5'd0; hif.D_tuse_rt = 2'd3;
    #1;
    chk_stall("rt_not_used", 1'b0);
    hif.D_tuse_rt = 2'd1; hif.D_rt = 5'd10;
    #1;
    chk_stall("rt_other_reg", 1'b0);
    step();
    chk_cnt("rt_cnt");
  endtask

  task automatic test_reg_zero();
    idle_inputs();
    hif.D_rs = 5'd0; hif.D_tuse_rs = 2'd0;
    hif.E_dst = 5'd0; hif.E_tnew = 2'd2;
    hif.D_rt = 5'd0; hif.D_tuse_rt = 2'd0;
    hif.M_dst = 5'd0; hif.M_tnew = 2'd2;
    #1;
    chk_stall("zero_reg", 1'b0);
    step();
    chk_cnt("zero_reg_cnt");
  endtask

  task automatic test_mult();
    idle_inputs();
    hif.E_md_start = 1'b1; hif.E_md_div = 1'b0; hif.D_md_use = 1'b1;
    #1;
    chk_stall("mult_issue_stall", 1'b1);
    chk_md("mult_issue_md", 1'b0, 1'b0);
    step(); exp_cnt += 1;
    hif.E_md_start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk_md($sformatf("mult_busy%0d", i), 1'b1, (i == 5));
      chk_stall($sformatf("mult_stall%0d", i), 1'b1);
      step(); exp_cnt += 1;
    end
    chk_md("mult_idle", 1'b0, 1'b0);
    chk_stall("mult_release", 1'b0);
    chk_cnt("mult_cnt");
    hif.D_md_use = 1'b0;
  endtask

  task automatic test_back_to_back();
    // A start while busy reloads the counter instead of decrementing.
    idle_inputs();
    hif.E_md_start = 1'b1; hif.E_md_div = 1'b0;
    step();
    hif.E_md_start = 1'b0;
    step();
    hif.E_md_start = 1'b1; hif.E_md_div = 1'b1;
    #1;
    chk_md("reload_before", 1'b1, 1'b0);
    step();
    hif.E_md_start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      #1;
      chk_md($sformatf("reload_busy%0d", i), 1'b1, (i == 10));
      step();
    end
    chk_md("reload_idle", 1'b0, 1'b0);
    chk_cnt("reload_cnt");
  endtask

  task automatic test_reset_mid_busy();
    idle_inputs();
    hif.E_md_start = 1'b1; hif.E_md_div = 1'b1;
    step();
    hif.E_md_start = 1'b0;
    for (int i = 1; i < 4; i++) step();
    chk_md("div_busy4", 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_md("abort_immediate", 1'b0, 1'b0);
    exp_cnt = 32'd0;
    chk_cnt("abort_cnt");
    step();
    reset = 1'b1;
    hif.D_md_use = 1'b1;
    #1;
    chk_stall("abort_md_use", 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (hif.md_done !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_done%0d: md_done=%b expected 0", i, hif.md_done);
      end
    end
    hif.D_md_use = 1'b0;
  endtask

  task automatic test_saturate();
    idle_inputs();
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    #1;
    exp_cnt = 32'hFFFF_FFFE;
    chk_cnt("sat_preset");
    hif.D_rs = 5'd3; hif.D_tuse_rs = 2'd0; hif.E_dst = 5'd3; hif.E_tnew = 2'd1;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_cnt = 32'hFFFF_FFFF;
      chk_cnt($sformatf("sat_stall%0d", i));
    end
    idle_inputs();
    step();
    chk_cnt("sat_hold");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_cnt = 32'd0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_raw_hazard();
    test_reg_zero();
    test_mult();
    test_back_to_back();
    test_reset_mid_busy();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
